// File: rtl/fxp_arb_pkg.sv
// Shared helper for the fixed-point add/sub arbiter slice.
// Only the requester-index width function lives here; all types stay local to each module.
package fxp_arb_pkg;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/comb_FixedPointAddSub.sv
// Combinational two's-complement fixed-point add/subtract.
// The sum is exact, then scaled to WOI.WOF (round or truncate) and saturated.
module comb_FixedPointAddSub #(
  parameter int WIIA  = 8,
  parameter int WIFA  = 8,
  parameter int WIIB  = 8,
  parameter int WIFB  = 8,
  parameter int WOI   = 8,
  parameter int WOF   = 8,
  parameter bit ROUND = 1'b1
) (
  input  logic [WIIA+WIFA-1:0] a,
  input  logic [WIIB+WIFB-1:0] b,
  input  logic                 sub,
  output logic [WOI+WOF-1:0]   result,
  output logic                 overflow
);

  localparam int WA = WIIA + WIFA;
  localparam int WB = WIIB + WIFB;
  localparam int WO = WOI + WOF;
  localparam int WF = (WIFA > WIFB) ? WIFA : WIFB;
  // Wide enough that neither negating min-negative nor any scaling can wrap.
  localparam int WX = WA + WB + WO + 4;

  localparam logic signed [WX-1:0] MAXV = {{(WX-WO+1){1'b0}}, {(WO-1){1'b1}}};
  localparam logic signed [WX-1:0] MINV = ~MAXV;

  logic signed [WX-1:0] a_x, b_x, sum_x, scaled_x;

  assign a_x   = signed'({{(WX-WA){a[WA-1]}}, a}) <<< (WF - WIFA);
  assign b_x   = signed'({{(WX-WB){b[WB-1]}}, b}) <<< (WF - WIFB);
  assign sum_x = sub ? (a_x - b_x) : (a_x + b_x);

  generate
    if (WOF >= WF) begin : g_up
      assign scaled_x = sum_x <<< (WOF - WF);
    end else begin : g_down
      localparam int D = WF - WOF;
      localparam logic signed [WX-1:0] HALF = WX'(ROUND) << (D - 1);
      assign scaled_x = (sum_x + HALF) >>> D;
    end
  endgenerate

  always_comb begin
    result   = scaled_x[WO-1:0];
    overflow = 1'b0;
    if (scaled_x > MAXV) begin
      result   = {1'b0, {(WO-1){1'b1}}};
      overflow = 1'b1;
    end else if (scaled_x < MINV) begin
      result   = {1'b1, {(WO-1){1'b0}}};
      overflow = 1'b1;
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// The search starts at ptr and wraps from NREQ-1 back to 0.
module rr_arbiter
  import fxp_arb_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = clog2_min1(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic            enable,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  int j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    if (enable) begin
      for (int k = 0; k < NREQ; k++) begin
        j = int'(ptr) + k;
        if (j >= NREQ) j = j - NREQ;
        if (!any && req[j]) begin
          grant[j] = 1'b1;
          idx      = IDW'(j);
          any      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fxp_addsub_arbiter.sv
// Shares one fixed-point add/sub datapath between NREQ requesters.
// Round-robin grant into a two-stage (operand, result) pipeline with backpressure.
module fxp_addsub_arbiter
  import fxp_arb_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int WII   = 8,
  parameter  int WIF   = 8,
  parameter  int WOI   = 8,
  parameter  int WOF   = 8,
  parameter  bit ROUND = 1'b1,
  localparam int IDW   = clog2_min1(NREQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [NREQ*(WII+WIF)-1:0]   req_a,
  input  logic [NREQ*(WII+WIF)-1:0]   req_b,
  input  logic [NREQ-1:0]             req_sub,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WOI+WOF-1:0]          out_data,
  output logic                        out_overflow,
  output logic [IDW-1:0]              out_id
);

  localparam int WI = WII + WIF;
  localparam int WO = WOI + WOF;

  logic [IDW-1:0] ptr_q, ptr_d, gnt_idx;
  logic           gnt_any, s1_free, s2_free;

  logic [WI-1:0]  a_q, a_d, b_q, b_d;
  logic           sub_q, sub_d, s1_valid_q, s1_valid_d;
  logic [IDW-1:0] id_q, id_d;

  logic [WO-1:0]  data_q, data_d, dp_result;
  logic           ovf_q, ovf_d, dp_ovf, ov_q, ov_d;
  logic [IDW-1:0] oid_q, oid_d;

  assign s2_free = !ov_q | out_ready;
  assign s1_free = !s1_valid_q | s2_free;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req    (req_valid),
    .enable (s1_free & !rst),
    .ptr    (ptr_q),
    .grant  (req_ready),
    .idx    (gnt_idx),
    .any    (gnt_any)
  );

  comb_FixedPointAddSub #(
    .WIIA(WII), .WIFA(WIF), .WIIB(WII), .WIFB(WIF),
    .WOI(WOI), .WOF(WOF), .ROUND(ROUND)
  ) u_dp (
    .a        (a_q),
    .b        (b_q),
    .sub      (sub_q),
    .result   (dp_result),
    .overflow (dp_ovf)
  );

  always_comb begin
    ptr_d      = ptr_q;
    a_d        = a_q;
    b_d        = b_q;
    sub_d      = sub_q;
    id_d       = id_q;
    s1_valid_d = s1_valid_q;
    data_d     = data_q;
    ovf_d      = ovf_q;
    oid_d      = oid_q;
    ov_d       = ov_q;
    if (gnt_any) begin
      // Winner drops to lowest priority for the next grant.
      ptr_d      = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
      a_d        = req_a[int'(gnt_idx)*WI +: WI];
      b_d        = req_b[int'(gnt_idx)*WI +: WI];
      sub_d      = req_sub[gnt_idx];
      id_d       = gnt_idx;
      s1_valid_d = 1'b1;
    end else if (s1_free) begin
      s1_valid_d = 1'b0;
    end
    if (s2_free) begin
      data_d = dp_result;
      ovf_d  = dp_ovf;
      oid_d  = id_q;
      ov_d   = s1_valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      sub_q      <= 1'b0;
      id_q       <= '0;
      s1_valid_q <= 1'b0;
      data_q     <= '0;
      ovf_q      <= 1'b0;
      oid_q      <= '0;
      ov_q       <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sub_q      <= sub_d;
      id_q       <= id_d;
      s1_valid_q <= s1_valid_d;
      data_q     <= data_d;
      ovf_q      <= ovf_d;
      oid_q      <= oid_d;
      ov_q       <= ov_d;
    end
  end

  assign out_valid    = ov_q;
  assign out_data     = data_q;
  assign out_overflow = ovf_q;
  assign out_id       = oid_q;

endmodule

// File: tb/tb_fxp_addsub_arbiter.sv
// Bench for fxp_addsub_arbiter: directed vectors plus randomized traffic
// checked against a capacity/round-robin/arithmetic reference model.
module tb_fxp_addsub_arbiter;

  localparam int NREQ = 4;
  localparam int WII = 8, WIF = 8, WOI = 8, WOF = 8;
  localparam bit ROUND = 1'b1;
  localparam int WI = WII + WIF;
  localparam int WO = WOI + WOF;
  localparam int IDW = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid, req_ready, req_sub;
  logic [NREQ*WI-1:0]   req_a, req_b;
  logic                 out_valid, out_ready, out_overflow;
  logic [WO-1:0]        out_data;
  logic [IDW-1:0]       out_id;

  fxp_addsub_arbiter #(.NREQ(NREQ), .WII(WII), .WIF(WIF), .WOI(WOI), .WOF(WOF), .ROUND(ROUND)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_overflow(out_overflow), .out_id(out_id)
  );

  always #5 clk = ~clk;

  typedef struct { int id; logic [WI-1:0] a; logic [WI-1:0] b; logic sub; } acc_t;
  typedef struct { int id; logic [WO-1:0] d; logic ovf; } res_t;

  int errors = 0, checks = 0;

  logic [WI-1:0] cur_a [NREQ];
  logic [WI-1:0] cur_b [NREQ];
  logic          cur_sub [NREQ];
  logic          cur_v [NREQ];

  acc_t acc_q[$];
  res_t out_q[$];
  int   exp_gnt_q[$];

  int mptr, inflight, max_inflight, ready_viol, gnt_viol, stab_viol;
  logic prev_stall;
  logic [WO-1:0] prev_d;
  logic [IDW-1:0] prev_id;
  logic prev_ovf;

  logic [NREQ-1:0] last_ready;
  logic o_v, o_ovf;
  logic [WO-1:0] o_d;
  logic [IDW-1:0] o_id;

  function automatic logic [WO:0] ref_calc(input logic [WI-1:0] a, input logic [WI-1:0] b, input logic sub);
    longint av, bv, x, mx, mn;
    int d;
    av = longint'($signed(a));
    bv = longint'($signed(b));
    x  = sub ? av - bv : av + bv;
    if (WOF >= WIF) x = x * (longint'(1) << (WOF - WIF));
    else begin
      d = WIF - WOF;
      if (ROUND) x = x + (longint'(1) << (d - 1));
      x = x >>> d;
    end
    mx = (longint'(1) << (WO - 1)) - 1;
    mn = -(longint'(1) << (WO - 1));
    if (x > mx) return {1'b1, WO'(mx)};
    if (x < mn) return {1'b1, WO'(mn)};
    return {1'b0, WO'(x)};
  endfunction

  task automatic apply();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*WI +: WI] = cur_a[i];
      req_b[i*WI +: WI] = cur_b[i];
      req_sub[i]        = cur_sub[i];
      req_valid[i]      = cur_v[i];
    end
  endtask

  task automatic new_ops(input int i);
    cur_a[i]   = WI'($urandom);
    cur_b[i]   = WI'($urandom);
    cur_sub[i] = 1'($urandom_range(0, 1));
  endtask

  // Samples one cycle (inputs already applied), updates the model, then advances the clock.
  task automatic tick();
    int w, gi, j;
    bit exp_any;
    #1;
    o_v = out_valid; o_d = out_data; o_id = out_id; o_ovf = out_overflow;
    last_ready = req_ready;
    if (rst) begin
      mptr = 0; inflight = 0; prev_stall = 1'b0;
      acc_q.delete(); out_q.delete(); exp_gnt_q.delete();
    end else begin
      exp_any = (req_valid != '0) && (inflight < 2 || out_ready);
      if ((req_ready != '0) != exp_any) ready_viol++;
      if (prev_stall && !(o_v && o_d == prev_d && o_id == prev_id && o_ovf == prev_ovf)) stab_viol++;
      if (req_ready != '0) begin
        w = -1;
        for (int k = 0; k < NREQ; k++) begin
          j = (mptr + k) % NREQ;
          if (w < 0 && req_valid[j]) w = j;
        end
        gi = 0;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) gi = i;
        if (w < 0 || req_ready != (NREQ'(1) << w)) gnt_viol++;
        exp_gnt_q.push_back(w);
        acc_q.push_back('{id: gi, a: req_a[gi*WI +: WI], b: req_b[gi*WI +: WI], sub: req_sub[gi]});
        if (w >= 0) mptr = (w + 1) % NREQ;
        inflight++;
      end
      if (o_v && out_ready) begin
        out_q.push_back('{id: int'(o_id), d: o_d, ovf: o_ovf});
        inflight--;
      end
      if (inflight > max_inflight) max_inflight = inflight;
      prev_stall = o_v && !out_ready;
      prev_d = o_d; prev_id = o_id; prev_ovf = o_ovf;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic post_grant(input bit keep);
    for (int i = 0; i < NREQ; i++) begin
      if (last_ready[i]) begin
        if (keep) new_ops(i);
        else cur_v[i] = 1'b0;
      end
    end
    apply();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ready_viol = 0; gnt_viol = 0; stab_viol = 0; max_inflight = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < NREQ; i++) cur_v[i] = 1'b0;
    out_ready = 1'b1;
    apply();
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic issue_one(input int id, input logic [WI-1:0] a, input logic [WI-1:0] b, input logic sub,
                           output logic [NREQ-1:0] g, output logic v1);
    for (int i = 0; i < NREQ; i++) cur_v[i] = 1'b0;
    cur_a[id] = a; cur_b[id] = b; cur_sub[id] = sub; cur_v[id] = 1'b1;
    out_ready = 1'b1;
    apply();
    tick();
    g = last_ready;
    cur_v[id] = 1'b0;
    apply();
    tick();
    v1 = o_v;
    tick();
  endtask

  task automatic test_reset();
    for (int i = 0; i < NREQ; i++) begin new_ops(i); cur_v[i] = 1'b1; end
    out_ready = 1'b1;
    apply();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (last_ready !== '0) begin errors++; $display("FAIL reset_ready: got %b expected 0", last_ready); end
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) cur_v[i] = 1'b0;
    apply();
    tick();
    checks++; if (o_v !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", o_v); end
    checks++; if (o_d !== '0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", o_d); end
    checks++; if (o_ovf !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", o_ovf); end
    checks++; if (o_id !== '0) begin errors++; $display("FAIL reset_out_id: got %0d expected 0", o_id); end
  endtask

  task automatic test_add();
    logic [NREQ-1:0] g; logic v1;
    issue_one(0, 16'h0180, 16'h0240, 1'b0, g, v1);
    checks++; if (g !== 4'b0001) begin errors++; $display("FAIL add_grant: got %b expected 0001", g); end
    checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL add_early_valid: got %b expected 0", v1); end
    checks++; if (o_v !== 1'b1) begin errors++; $display("FAIL add_latency: got out_valid %b expected 1", o_v); end
    checks++; if (o_d !== 16'h03C0) begin errors++; $display("FAIL add_data: got %h expected 03c0", o_d); end
    checks++; if (o_id !== 2'd0 || o_ovf !== 1'b0) begin errors++; $display("FAIL add_id_ovf: got %0d/%b expected 0/0", o_id, o_ovf); end
    idle(2);
  endtask

  task automatic test_sub();
    logic [NREQ-1:0] g; logic v1;
    issue_one(2, 16'h0100, 16'h0300, 1'b1, g, v1);
    checks++; if (g !== 4'b0100) begin errors++; $display("FAIL sub_grant: got %b expected 0100", g); end
    checks++; if (o_v !== 1'b1 || o_d !== 16'hFE00) begin errors++; $display("FAIL sub_data: got %b/%h expected 1/fe00", o_v, o_d); end
    checks++; if (o_id !== 2'd2 || o_ovf !== 1'b0) begin errors++; $display("FAIL sub_id_ovf: got %0d/%b expected 2/0", o_id, o_ovf); end
    idle(2);
  endtask

  task automatic test_saturation();
    logic [NREQ-1:0] g; logic v1;
    int          tid [4] = '{1, 3, 0, 2};
    logic [15:0] ta  [4] = '{16'h7F00, 16'h8000, 16'h0000, 16'hFF00};
    logic [15:0] tb  [4] = '{16'h0100, 16'h0100, 16'h8000, 16'h8000};
    logic        ts  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [15:0] te  [4] = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h7F00};
    logic        tov [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 4; k++) begin
      issue_one(tid[k], ta[k], tb[k], ts[k], g, v1);
      checks++;
      if (o_v !== 1'b1 || o_d !== te[k] || o_ovf !== tov[k] || int'(o_id) != tid[k]) begin
        errors++;
        $display("FAIL sat_case%0d: got v=%b d=%h ovf=%b id=%0d expected v=1 d=%h ovf=%b id=%0d",
                 k, o_v, o_d, o_ovf, o_id, te[k], tov[k], tid[k]);
      end
      idle(2);
    end
  endtask

  task automatic test_fairness();
    logic [WO:0] r;
    int bad;
    do_reset();
    for (int i = 0; i < NREQ; i++) begin new_ops(i); cur_v[i] = 1'b1; end
    out_ready = 1'b1;
    apply();
    for (int c = 0; c < 16; c++) begin tick(); post_grant(1'b1); end
    checks++; if (out_q.size() != 14) begin errors++; $display("FAIL fair_throughput: got %0d results expected 14", out_q.size()); end
    bad = 0;
    for (int k = 0; k < out_q.size() && k < acc_q.size(); k++) begin
      r = ref_calc(acc_q[k].a, acc_q[k].b, acc_q[k].sub);
      checks++;
      if (out_q[k].id != k % NREQ || out_q[k].d !== r[WO-1:0] || out_q[k].ovf !== r[WO]) begin
        errors++; bad++;
        if (bad < 5) $display("FAIL fair_result%0d: got id=%0d d=%h ovf=%b expected id=%0d d=%h ovf=%b",
                              k, out_q[k].id, out_q[k].d, out_q[k].ovf, k % NREQ, r[WO-1:0], r[WO]);
      end
    end
    checks++; if (gnt_viol != 0) begin errors++; $display("FAIL fair_grant_order: got %0d wrong grants expected 0", gnt_viol); end
    idle(3);
  endtask

  task automatic test_back_pressure();
    logic [WO:0] r;
    int mask, c;
    do_reset();
    for (int i = 0; i < NREQ; i++) begin new_ops(i); cur_v[i] = 1'b1; end
    out_ready = 1'b0;
    apply();
    for (int k = 0; k < 5; k++) begin tick(); post_grant(1'b0); end
    checks++; if (acc_q.size() != 2) begin errors++; $display("FAIL bp_grants: got %0d expected 2", acc_q.size()); end
    checks++; if (o_v !== 1'b1 || out_q.size() != 0) begin errors++; $display("FAIL bp_hold: got valid=%b taken=%0d expected 1/0", o_v, out_q.size()); end
    checks++; if (stab_viol != 0) begin errors++; $display("FAIL bp_stable: got %0d changes expected 0", stab_viol); end
    out_ready = 1'b1;
    c = 0;
    while (out_q.size() < 4 && c < 20) begin tick(); post_grant(1'b0); c++; end
    checks++; if (out_q.size() != 4) begin errors++; $display("FAIL bp_drain: got %0d results expected 4", out_q.size()); end
    mask = 0;
    for (int k = 0; k < out_q.size() && k < acc_q.size(); k++) begin
      r = ref_calc(acc_q[k].a, acc_q[k].b, acc_q[k].sub);
      mask = mask | (1 << out_q[k].id);
      checks++;
      if (out_q[k].id != acc_q[k].id || out_q[k].d !== r[WO-1:0] || out_q[k].ovf !== r[WO]) begin
        errors++;
        $display("FAIL bp_result%0d: got id=%0d d=%h expected id=%0d d=%h", k, out_q[k].id, out_q[k].d, acc_q[k].id, r[WO-1:0]);
      end
    end
    checks++; if (mask != 4'hF) begin errors++; $display("FAIL bp_unique: got id mask %h expected f", mask); end
    idle(3);
    checks++; if (out_q.size() != 4) begin errors++; $display("FAIL bp_duplicate: got %0d results expected 4", out_q.size()); end
  endtask

  task automatic test_random();
    logic [WO:0] r;
    int bad;
    do_reset();
    for (int i = 0; i < NREQ; i++) cur_v[i] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!cur_v[i]) begin
          if ($urandom_range(0, 2) == 0) begin new_ops(i); cur_v[i] = 1'b1; end
        end else if ($urandom_range(0, 15) == 0) cur_v[i] = 1'b0;
      end
      apply();
      tick();
      post_grant(1'b0);
    end
    idle(6);
    checks++; if (ready_viol != 0) begin errors++; $display("FAIL rand_ready: got %0d wrong ready cycles expected 0", ready_viol); end
    checks++; if (gnt_viol != 0) begin errors++; $display("FAIL rand_rr: got %0d wrong grants expected 0", gnt_viol); end
    checks++; if (stab_viol != 0) begin errors++; $display("FAIL rand_stable: got %0d changes expected 0", stab_viol); end
    checks++; if (max_inflight > 2) begin errors++; $display("FAIL rand_capacity: got %0d in flight expected <=2", max_inflight); end
    checks++; if (out_q.size() != acc_q.size()) begin errors++; $display("FAIL rand_count: got %0d results expected %0d", out_q.size(), acc_q.size()); end
    bad = 0;
    for (int k = 0; k < out_q.size() && k < acc_q.size(); k++) begin
      r = ref_calc(acc_q[k].a, acc_q[k].b, acc_q[k].sub);
      checks++;
      if (out_q[k].id != acc_q[k].id || out_q[k].d !== r[WO-1:0] || out_q[k].ovf !== r[WO]) begin
        errors++; bad++;
        if (bad < 5) $display("FAIL rand_result%0d: got id=%0d d=%h ovf=%b expected id=%0d d=%h ovf=%b",
                              k, out_q[k].id, out_q[k].d, out_q[k].ovf, acc_q[k].id, r[WO-1:0], r[WO]);
      end
    end
  endtask

  task automatic test_reset_midflight();
    logic [WO:0] r;
    do_reset();
    for (int i = 0; i < NREQ; i++) begin new_ops(i); cur_v[i] = 1'b1; end
    out_ready = 1'b0;
    apply();
    for (int k = 0; k < 3; k++) begin tick(); post_grant(1'b0); end
    checks++; if (acc_q.size() != 2) begin errors++; $display("FAIL mid_fill: got %0d grants expected 2", acc_q.size()); end
    do_reset();
    for (int i = 0; i < NREQ; i++) cur_v[i] = 1'b0;
    new_ops(0); new_ops(3);
    cur_v[0] = 1'b1; cur_v[3] = 1'b1;
    out_ready = 1'b1;
    apply();
    tick();
    checks++; if (o_v !== 1'b0) begin errors++; $display("FAIL mid_flush: got out_valid %b expected 0", o_v); end
    checks++; if (last_ready !== 4'b0001) begin errors++; $display("FAIL mid_ptr: got grant %b expected 0001", last_ready); end
    post_grant(1'b0);
    tick();
    post_grant(1'b0);
    idle(5);
    checks++; if (out_q.size() != 2) begin errors++; $display("FAIL mid_count: got %0d results expected 2", out_q.size()); end
    if (out_q.size() > 0 && acc_q.size() > 0) begin
      r = ref_calc(acc_q[0].a, acc_q[0].b, acc_q[0].sub);
      checks++;
      if (out_q[0].id != 0 || out_q[0].d !== r[WO-1:0]) begin
        errors++; $display("FAIL mid_first: got id=%0d d=%h expected id=0 d=%h", out_q[0].id, out_q[0].d, r[WO-1:0]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b1;
    req_valid = '0; req_a = '0; req_b = '0; req_sub = '0;
    for (int i = 0; i < NREQ; i++) begin cur_a[i] = '0; cur_b[i] = '0; cur_sub[i] = 1'b0; cur_v[i] = 1'b0; end
    mptr = 0; inflight = 0; max_inflight = 0; ready_viol = 0; gnt_viol = 0; stab_viol = 0;
    prev_stall = 1'b0; prev_d = '0; prev_id = '0; prev_ovf = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_add();
    test_sub();
    test_saturation();
    test_fairness();
    test_back_pressure();
    test_random();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
